fp_norm_round: RTL
==================

# fp_norm_round

Sequential normalize-and-round stage for the single-precision FP adder, sitting directly downstream of `bigALU`. It accepts the 27-bit raw mantissa sum (hidden bit, 23 fraction, guard/round/sticky), the ALU carry, the result sign and the pre-alignment exponent. It normalizes one bit per cycle, rounds to nearest-even and emits the packed IEEE-754 word with status flags.

## Interface
- `MW`, default 27: raw mantissa width. Bit 26 is hidden, bits 25:3 are fraction, bit 2 is G, bit 1 is R, bit 0 is S.
- `EW`, default 8: exponent width.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request. Sampled only in IDLE.
- `mant_in` in MW: `bigALU` result.
- `carry_in` in 1: `bigALU` carry.
- `sign_in` in 1: result sign.
- `exp_in` in EW: larger operand's biased exponent. The caller guarantees 1..254.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when `result` becomes valid.
- `result` out 32: packed {sign, exp, frac}. Held until the next accepted `start`.
- `overflow` out 1: held with `result`.
- `underflow` out 1: held with `result`.
- `zero` out 1: held with `result`.

## Operation
- States: IDLE, PRE, NORM, ROUND, DONE.
- IDLE:
  - On `start`, capture the inputs into internal registers `m` (MW bits), `e` (EW+1 bits) and `s`, then go to PRE.
  - `start` is ignored in every other state.
- PRE:
  - If `carry_in` was set: `m = {1, m[26:2], m[1]|m[0]}` (sticky absorbs the dropped bit), `e = e+1`, go to ROUND.
  - Else if `m == 0`: result is +0, `zero=1`, sign forced to 0, go to DONE.
  - Else if `m[26]`: go to ROUND.
  - Else go to NORM.
- NORM, each cycle:
  - If `e == 1`: flush to signed zero, `underflow=1`, `zero=1`, go to DONE. Subnormals are not produced.
  - Else: `m = m << 1`, `e = e-1`. If the pre-shift `m[25]` was 1, go to ROUND; otherwise stay in NORM.
- ROUND, round-to-nearest-even:
  - `up = G & (R | S | m[3])`.
  - 25-bit sum = `{0, m[26:3]} + up`.
  - If sum bit 24 is set: take fraction `sum[23:1]`, `e = e+1`.
  - If `e >= 255`: `result = {s, 8'hFF, 0}`, `overflow=1`.
  - Go to DONE.
- DONE: `done=1` for exactly one cycle. Flags and `result` are registered, then go to IDLE.
- Flags are cleared when a new `start` is accepted.

## Timing
- Reset: state IDLE, `busy=0`, `done=0`, `result=0`, all flags 0. This takes effect immediately and asynchronously, including mid-NORM. Any in-flight operation is discarded with no `done`.
- Latency, with k = left shifts required:
  - `done` is high in the cycle after the (k+2)th rising edge following the edge that sampled `start`.
  - k=0: 3 cycles start-to-done inclusive. Maximum k=26.
- Back-to-back: the earliest next `start` is sampled on the edge leaving DONE (state IDLE is entered) plus one cycle. `busy` is low in IDLE only.
- Simultaneous: `start` in DONE is ignored. The source must hold `start` until `busy` drops.

## Structure
- Shared `fp_pkg`:
  - Constants `FP_BIAS=127`, `EXP_MAX=8'hFF`, `MW=27`, `FRAC_W=23`.
  - State enum `norm_state_t`.
  - Bit-index constants `HID=26`, `G_BIT=2`, `R_BIT=1`, `S_BIT=0`.
- One natural sub-module: `fp_rne_round`, combinational. Inputs: m, e. Outputs: rounded frac, adjusted exp, overflow. It is reusable by the future multiplier stage.

## Test plan
- `mant_in=27'h4000000`, `exp_in=127`, carry 0, sign 0 -> `result=32'h3F800000`, `done` in cycle 3.
- `mant_in=0`, carry 1, `exp_in=127` (the `bigALU` case 0x7FFFFFF+1) -> `32'h40000000`. With `exp_in=254` -> `32'h7F800000`, `overflow=1`.
- `mant_in=27'h0000008`, `exp_in=127` -> k=23, `32'h34000000`, `done` in cycle 26. With `exp_in=2` -> `result=0`, `underflow=1`, `zero=1`.
- Rounding cases, all with `exp_in=127`:
  - `27'h7FFFFFC` -> round overflow to `32'h40000000`.
  - `27'h4000004` (tie, even) -> `32'h3F800000`.
  - `27'h400000C` (tie, odd) -> `32'h3F800002`.
- Zero case: `mant_in=0`, carry 0, `sign_in=1` -> `result=32'h00000000`, `zero=1`.
- Reset mid-operation: drop `rst_n` during NORM of the k=23 case -> outputs 0 immediately and no `done`. Then a fresh `start` completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, bit positions and state encoding for the FP adder back-end stages.
package fp_pkg;
   localparam int         FP_BIAS = 127;
   localparam logic [7:0] EXP_MAX = 8'hFF;
   localparam int         MW      = 27;
   localparam int         FRAC_W  = 23;

   // Raw mantissa layout: hidden | 23 fraction | guard | round | sticky
   localparam int HID   = 26;
   localparam int G_BIT = 2;
   localparam int R_BIT = 1;
   localparam int S_BIT = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } norm_state_t;
endpackage

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even of a normalized raw mantissa, with exponent
// adjustment and saturation to infinity on exponent overflow.
module fp_rne_round
   import fp_pkg::*;
#(
   parameter int EW = 8
) (
   input  logic [MW-1:0]     m,
   input  logic [EW:0]       e,
   output logic [FRAC_W-1:0] frac,
   output logic [EW-1:0]     exp_adj,
   output logic              overflow
);
   logic              up;
   logic [FRAC_W+1:0] sum;
   logic [EW:0]       e_adj;

   always_comb begin
      up  = m[G_BIT] & (m[R_BIT] | m[S_BIT] | m[G_BIT+1]);
      sum = {1'b0, m[HID:G_BIT+1]} + {{(FRAC_W+1){1'b0}}, up};
      // A carry out of the hidden bit renormalizes by one position
      if (sum[FRAC_W+1]) begin
         frac  = sum[FRAC_W:1];
         e_adj = e + 1'b1;
      end else begin
         frac  = sum[FRAC_W-1:0];
         e_adj = e;
      end
      overflow = (e_adj >= {1'b0, EXP_MAX});
      exp_adj  = e_adj[EW-1:0];
      if (overflow) begin
         frac    = '0;
         exp_adj = EXP_MAX;
      end
   end
endmodule

// File: rtl/fp_norm_round.sv
// Sequential normalize (one left shift per cycle) and round stage for the FP adder,
// producing the packed single-precision word and status flags.
module fp_norm_round #(
   parameter int MW = 27,
   parameter int EW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [MW-1:0] mant_in,
   input  logic          carry_in,
   input  logic          sign_in,
   input  logic [EW-1:0] exp_in,
   output logic          busy,
   output logic          done,
   output logic [31:0]   result,
   output logic          overflow,
   output logic          underflow,
   output logic          zero
);
   import fp_pkg::*;

   norm_state_t       state_reg;
   logic [MW-1:0]     m_reg;
   logic [EW:0]       e_reg;
   logic              s_reg;
   logic              carry_reg;

   logic [FRAC_W-1:0] rnd_frac;
   logic [EW-1:0]     rnd_exp;
   logic              rnd_ovf;

   fp_rne_round #(
      .EW(EW)
   ) u_round (
      .m        (m_reg),
      .e        (e_reg),
      .frac     (rnd_frac),
      .exp_adj  (rnd_exp),
      .overflow (rnd_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         m_reg     <= '0;
         e_reg     <= '0;
         s_reg     <= 1'b0;
         carry_reg <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         zero      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  m_reg     <= mant_in;
                  e_reg     <= {1'b0, exp_in};
                  s_reg     <= sign_in;
                  carry_reg <= carry_in;
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
                  zero      <= 1'b0;
                  busy      <= 1'b1;
                  state_reg <= ST_PRE;
               end
            end
            ST_PRE: begin
               if (carry_reg) begin
                  // Carry out: shift right once, folding the dropped bit into sticky
                  m_reg     <= {1'b1, m_reg[HID:G_BIT], m_reg[R_BIT] | m_reg[S_BIT]};
                  e_reg     <= e_reg + 1'b1;
                  state_reg <= ST_ROUND;
               end else if (m_reg == '0) begin
                  result    <= '0;
                  zero      <= 1'b1;
                  done      <= 1'b1;
                  state_reg <= ST_DONE;
               end else if (m_reg[HID]) begin
                  state_reg <= ST_ROUND;
               end else begin
                  state_reg <= ST_NORM;
               end
            end
            ST_NORM: begin
               if (e_reg == (EW+1)'(1)) begin
                  result    <= {s_reg, 31'b0};
                  underflow <= 1'b1;
                  zero      <= 1'b1;
                  done      <= 1'b1;
                  state_reg <= ST_DONE;
               end else begin
                  m_reg <= m_reg << 1;
                  e_reg <= e_reg - 1'b1;
                  if (m_reg[HID-1]) begin
                     state_reg <= ST_ROUND;
                  end
               end
            end
            ST_ROUND: begin
               result    <= {s_reg, rnd_exp, rnd_frac};
               overflow  <= rnd_ovf;
               done      <= 1'b1;
               state_reg <= ST_DONE;
            end
            ST_DONE: begin
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
